// File: rtl/ks_adder_pipe_if.sv
// Valid/ready operand and result bundle for ks_adder_pipe.
// Optional macro KS_OVF_EN adds the out_ovf signed-overflow result signal.
interface ks_adder_pipe_if #(
  parameter int WIDTH = 25,
  parameter int TAG_W = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;
`ifdef KS_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_tag
`ifdef KS_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_tag
`ifdef KS_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor, one register rank per prefix level, global stall.
// Optional macro KS_OVF_EN enables the out_ovf signed-overflow output.
module ks_adder_pipe #(
  parameter int WIDTH = 25,
  parameter int TAG_W = 1
) (
  input  logic          clock,
  input  logic          resetn,
  ks_adder_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;

  // Rank 0 holds bitwise P/G; rank k holds the result of prefix level k.
  logic             vld_q [0:LEVELS];
  logic             vld_d [0:LEVELS];
  word_t            p_q   [0:LEVELS];
  word_t            p_d   [0:LEVELS];
  word_t            g_q   [0:LEVELS];
  word_t            g_d   [0:LEVELS];
  word_t            p0_q  [0:LEVELS];
  word_t            p0_d  [0:LEVELS];
  logic             c0_q  [0:LEVELS];
  logic             c0_d  [0:LEVELS];
  logic [TAG_W-1:0] tag_q [0:LEVELS];
  logic [TAG_W-1:0] tag_d [0:LEVELS];

  word_t g_src [1:LEVELS];
  word_t b_mod;
  word_t sum;
  logic  advance;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    advance = !vld_q[LEVELS] || bus.out_ready;
    b_mod   = bus.in_b ^ {WIDTH{bus.in_sub}};

    vld_d[0] = bus.in_valid;
    c0_d[0]  = bus.in_sub | bus.in_cin;
    p_d[0]   = bus.in_a ^ b_mod;
    g_d[0]   = bus.in_a & b_mod;
    p0_d[0]  = bus.in_a ^ b_mod;
    tag_d[0] = bus.in_tag;

    for (int k = 1; k <= LEVELS; k++) begin
      g_src[k] = g_q[k-1];
      // Carry-in is folded into bit 0 so the prefix tree sees it as a generate.
      if (k == 1) begin
        g_src[k][0] = g_q[0][0] | (p_q[0][0] & c0_q[0]);
      end

      vld_d[k] = vld_q[k-1];
      c0_d[k]  = c0_q[k-1];
      p0_d[k]  = p0_q[k-1];
      tag_d[k] = tag_q[k-1];
      g_d[k]   = g_src[k];
      p_d[k]   = p_q[k-1];

      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (k - 1))) begin
          g_d[k][i] = g_src[k][i]
                    | (p_q[k-1][i] & g_src[k][(i >= (1 << (k - 1))) ? i - (1 << (k - 1)) : i]);
          p_d[k][i] = p_q[k-1][i]
                    & p_q[k-1][(i >= (1 << (k - 1))) ? i - (1 << (k - 1)) : i];
        end
      end
    end

    sum = p0_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
  end

  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: data ranks are reset too, so the combinational sum reads 0 straight out of reset.
    if (!resetn) begin
      for (int r = 0; r <= LEVELS; r++) begin
        vld_q[r] <= 1'b0;
        p_q[r]   <= '0;
        g_q[r]   <= '0;
        p0_q[r]  <= '0;
        c0_q[r]  <= 1'b0;
        tag_q[r] <= '0;
      end
    end else if (advance) begin
      for (int r = 0; r <= LEVELS; r++) begin
        vld_q[r] <= vld_d[r];
        p_q[r]   <= p_d[r];
        g_q[r]   <= g_d[r];
        p0_q[r]  <= p0_d[r];
        c0_q[r]  <= c0_d[r];
        tag_q[r] <= tag_d[r];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[LEVELS];
  assign bus.out_sum   = sum;
  assign bus.out_cout  = g_q[LEVELS][WIDTH-1];
  assign bus.out_tag   = tag_q[LEVELS];

`ifdef KS_OVF_EN
  // Group generate of bits [WIDTH-2:0] (c0 already folded in) is exactly the carry into the MSB.
  assign bus.out_ovf = g_q[LEVELS][WIDTH-2] ^ g_q[LEVELS][WIDTH-1];
`endif
endmodule
